regfile_mp: RTL

Parametrised multi-port integer register file. It is the successor to the single-write, dual-read core register file and adds:
- configurable data width, register count, read-port count and write-port count;
- optional write-to-read bypass;
- a sequential clear engine that zeroes the array after reset or on request.

Sits in decode/writeback of the core. Entry 0 is hard-wired to zero.

---
 rtl/regfile_mp.sv | 89 ++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with optional bypass and sequential clear engine
// Entry 0 reads as zero; the clear engine zeroes entries 1..NREGS-1 after reset or on request.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 0,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_req,
  output logic                ready,
  input  logic [NRD*AW-1:0]   rs,
  output logic [NRD*XLEN-1:0] rs_data,
  input  logic [NWR-1:0]      we_n,
  input  logic [NWR*AW-1:0]   rd,
  input  logic [NWR*XLEN-1:0] wd
);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t            r_state;
  logic [AW-1:0]     r_clr_idx;
  logic              r_ready;
  logic [XLEN-1:0]   r_regs [NREGS];
  logic [NRD*XLEN-1:0] w_rs_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_clr_idx <= AW'(1);
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (clr_req) begin
            r_clr_idx <= AW'(1);
          end else begin
            r_clr_idx <= r_clr_idx + AW'(1);
            if (r_clr_idx == AW'(NREGS - 1)) begin
              r_state <= S_IDLE;
              r_ready <= 1'b1;
            end
          end
        end
        default: begin
          if (clr_req) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= AW'(1);
            r_ready   <= 1'b0;
          end
        end
      endcase
    end
  end

  // Higher-numbered ports are visited last, so they win on an address collision.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_regs[r_clr_idx] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (!we_n[j] && rd[j*AW +: AW] != '0)
          r_regs[rd[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    w_rs_data = '0;
    for (int i = 0; i < NRD; i++) begin
      if (r_state == S_IDLE && rs[i*AW +: AW] != '0) begin
        w_rs_data[i*XLEN +: XLEN] = r_regs[rs[i*AW +: AW]];
        if (BYPASS != 0) begin
          for (int j = 0; j < NWR; j++) begin
            if (!we_n[j] && rd[j*AW +: AW] != '0 && rd[j*AW +: AW] == rs[i*AW +: AW])
              w_rs_data[i*XLEN +: XLEN] = wd[j*XLEN +: XLEN];
          end
        end
      end
    end
  end

  assign ready   = r_ready;
  assign rs_data = w_rs_data;

endmodule
